// File: rtl/spike_encoder.sv
// Temporal spike transmitter: each lane value becomes a rising edge at that
// gamma-relative time, held for PULSE_WIDTH cycles, with a double-buffered input.
module spike_encoder #(
    parameter  int NUM_OUTPUTS       = 8,
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int PULSE_WIDTH       = 8,
    parameter  int VAL_WIDTH         = 4,
    localparam int GW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_OUTPUTS*VAL_WIDTH-1:0] in_values,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [NUM_OUTPUTS-1:0]           output_spikes,
    output logic                             gamma_start,
    output logic [GW-1:0]                    gamma_count
);

    localparam int                   VEC_W    = NUM_OUTPUTS * VAL_WIDTH;
    localparam logic [GW-1:0]        G_LAST   = GW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [VAL_WIDTH-1:0] NULL_VAL = '1;
    localparam logic [VEC_W-1:0]     NULL_VEC = '1;
    localparam logic [31:0]          GCW_U    = GAMMA_CYCLE_WIDTH;
    localparam logic [31:0]          PW_U     = PULSE_WIDTH;

    logic [GW-1:0]    gamma_q, gamma_d;
    logic [VEC_W-1:0] active_q, active_d;
    logic [VEC_W-1:0] pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic             boundary;
    logic             transfer;

    assign in_ready    = rst && !pending_valid_q;
    assign gamma_start = rst && (gamma_q == '0);
    assign gamma_count = gamma_q;

    always_comb begin
        boundary        = (gamma_q == G_LAST);
        transfer        = in_valid && in_ready;
        gamma_d         = boundary ? '0 : gamma_q + GW'(1);
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;

        // Boundary reloads the active vector; an empty slot yields a silent gamma.
        if (boundary) begin
            if (pending_valid_q) begin
                active_d        = pending_q;
                pending_valid_d = 1'b0;
            end else if (transfer) begin
                active_d = in_values;
            end else begin
                active_d = NULL_VEC;
            end
        end else if (transfer) begin
            pending_d       = in_values;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gamma_q         <= G_LAST;
            active_q        <= NULL_VEC;
            pending_q       <= NULL_VEC;
            pending_valid_q <= 1'b0;
        end else begin
            gamma_q         <= gamma_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    // Compare in 32 bits so t + PULSE_WIDTH cannot wrap; pulses end naturally at g wrap.
    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lane
        logic [VAL_WIDTH-1:0] t;
        logic [31:0]          t_ext;
        logic [31:0]          g_ext;
        logic                 lane_null;

        assign t             = active_q[i*VAL_WIDTH +: VAL_WIDTH];
        assign t_ext         = 32'(t);
        assign g_ext         = 32'(gamma_q);
        assign lane_null     = (t == NULL_VAL) || (t_ext >= GCW_U);
        assign output_spikes[i] = !lane_null && (g_ext >= t_ext) && (g_ext < t_ext + PW_U);
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: reset, bypass, pending path, backpressure,
// ties, truncation and mid-pulse reset with hand-derived spike windows.
module tb_spike_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_values;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  output_spikes;
    logic        gamma_start;
    logic [3:0]  gamma_count;

    int n_vec  = 0;
    int n_miss = 0;

    spike_encoder #(
        .NUM_OUTPUTS      (8),
        .GAMMA_CYCLE_WIDTH(16),
        .PULSE_WIDTH      (8),
        .VAL_WIDTH        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_values    (in_values),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .output_spikes(output_spikes),
        .gamma_start  (gamma_start),
        .gamma_count  (gamma_count)
    );

    always #5 clk = ~clk;

    // Lane vectors, lane7 nibble leftmost.
    localparam logic [31:0] V1 = 32'hFFFF2FF0;  // lane0=0, lane3=2
    localparam logic [31:0] V2 = 32'hFECFFFFF;  // lane5=12, lane6=14
    localparam logic [31:0] VA = 32'hFF77FF7F;  // lanes 1,4,5 = 7
    localparam logic [31:0] VB = 32'hAFFFF9FF;  // lane2=9, lane7=10 (both truncated)
    localparam logic [31:0] VC = 32'hFFFFFFF0;  // lane0=0
    localparam logic [31:0] VD = 32'h3FFFFFFF;  // lane7=3, discarded by reset

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spike mask m high for g in [lo, hi]; 8 bits per g slot.
    function automatic logic [127:0] win(input int lo, input int hi, input logic [7:0] m);
        logic [127:0] r;
        r = '0;
        for (int g = lo; g <= hi; g++) r[g*8 +: 8] = m;
        return r;
    endfunction

    // Walk one gamma from g=0 to last_g; in_ready expected high for g <= rdy_last.
    task automatic play(input logic [127:0] exp_sp, input int rdy_last, input int last_g,
                        input int s1_g, input logic [31:0] s1_v,
                        input int s2_g, input logic [31:0] s2_v);
        for (int g = 0; g <= last_g; g++) begin
            if (g == s1_g) begin in_values = s1_v; in_valid = 1'b1; end
            if (g == s2_g) begin in_values = s2_v; in_valid = 1'b1; end
            chk($sformatf("gcnt g%0d", g), 32'(gamma_count), 32'(g));
            chk($sformatf("gstart g%0d", g), 32'(gamma_start), 32'(g == 0));
            chk($sformatf("spk g%0d", g), 32'(output_spikes), 32'(exp_sp[g*8 +: 8]));
            chk($sformatf("rdy g%0d", g), 32'(in_ready), 32'(g <= rdy_last));
            tick();
            if (in_valid && g <= rdy_last) in_valid = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_values = '1;

        repeat (3) begin
            tick();
            chk("rst spk", 32'(output_spikes), 32'h0);
            chk("rst gstart", 32'(gamma_start), 32'h0);
            chk("rst rdy", 32'(in_ready), 32'h0);
            chk("rst gcnt", 32'(gamma_count), 32'd15);
        end

        // First cycle after release is a boundary; vector goes straight to active.
        rst = 1'b1;
        #1;
        chk("rel gcnt", 32'(gamma_count), 32'd15);
        chk("rel rdy", 32'(in_ready), 32'h1);
        chk("rel gstart", 32'(gamma_start), 32'h0);
        in_values = V1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;

        play(win(0, 7, 8'h01) | win(2, 9, 8'h08), 15, 15, -1, '0, -1, '0);
        play('0, 1, 15, 1, V2, -1, '0);
        play(win(12, 15, 8'h20) | win(14, 15, 8'h40), 15, 15, -1, '0, -1, '0);
        play('0, 3, 15, 3, VA, 4, VB);
        play(win(7, 14, 8'h32), 0, 15, -1, '0, -1, '0);
        play(win(9, 15, 8'h04) | win(10, 15, 8'h80), 2, 15, 2, VC, -1, '0);
        play(win(0, 4, 8'h01), 1, 4, 1, VD, -1, '0);

        chk("pre-rst spk g5", 32'(output_spikes), 32'h01);
        chk("pre-rst rdy g5", 32'(in_ready), 32'h0);
        rst = 1'b0;
        tick();
        chk("midrst spk", 32'(output_spikes), 32'h0);
        chk("midrst gstart", 32'(gamma_start), 32'h0);
        chk("midrst rdy", 32'(in_ready), 32'h0);
        chk("midrst gcnt", 32'(gamma_count), 32'd15);
        rst = 1'b1;
        #1;
        chk("rel2 rdy", 32'(in_ready), 32'h1);
        chk("rel2 spk", 32'(output_spikes), 32'h0);
        tick();
        play('0, 15, 15, -1, '0, -1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
